// File: rtl/vec_pipe_pkg.sv
// Shared types for the vector pipeline control logic.
//   fwd_sel_t  : E-stage operand mux select (regfile / ResultW / ALUOutM)
//   reg_cls_t  : register class of an operand or destination
//   mc_state_t : multi-cycle execute sequencer state
package vec_pipe_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        CLS_SCALAR = 1'b0,
        CLS_VECTOR = 1'b1
    } reg_cls_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mc_state_t;

    // M holds the younger result, so it wins over W.
    function automatic fwd_sel_t pick_fwd(input logic hit_m, input logic hit_w);
        if (hit_m) begin
            return FWD_MEM;
        end else if (hit_w) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/vec_mc_sequencer.sv
// Multi-cycle execute sequencer. Keeps a multi-cycle op in E for MC_LAT cycles.
//   clk, rst     : clock, asynchronous active-high reset
//   multicycle_e : E-stage op is multi-cycle
//   hold         : freeze F/D/E and bubble M this cycle (combinational)
//   ex_busy      : sequencer is in BUSY (straight from the state register)
module vec_mc_sequencer
    import vec_pipe_pkg::*;
#(
    parameter int unsigned MC_LAT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic multicycle_e,
    output logic hold,
    output logic ex_busy
);

    localparam int unsigned CntW    = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;
    localparam bit          HasHold = (MC_LAT > 1);
    // First cycle in IDLE already counts, so BUSY runs MC_LAT-1 more cycles.
    localparam logic [CntW-1:0] CntInit = HasHold ? CntW'(MC_LAT - 2) : '0;

    mc_state_t       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (multicycle_e && HasHold) begin
                    hold    = 1'b1;
                    cnt_d   = CntInit;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    hold  = 1'b1;
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    // Op leaves E now; a still-high multicycle_e is ignored.
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ex_busy = (state_q == BUSY);

endmodule

// File: rtl/vec_hazard_unit.sv
// Hazard unit for the five-stage vector pipeline.
//   clk, rst                    : clock, asynchronous active-high reset
//   ra_*/rcls_*/ruse_* (D, E)   : per-operand source address, class, valid
//   wa_*/wcls_*/regwrite_*      : destination of the E, M and W stages
//   memtoreg_e, multicycle_e    : E-stage load / multi-cycle op flags
//   branch_taken_e              : taken branch resolved in E
//   fwd_e                       : per-operand E-stage operand mux select
//   stall_f/d/e, flush_d/e/m    : pipeline register enables and clears
//   ex_busy                     : multi-cycle sequence in progress
//   lu_stall_cnt                : saturating count of load-use stall cycles
module vec_hazard_unit
    import vec_pipe_pkg::*;
#(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned NSRC   = 3,
    parameter int unsigned MC_LAT = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NSRC-1:0][ADDR_W-1:0]  ra_d,
    input  logic [NSRC-1:0]              rcls_d,
    input  logic [NSRC-1:0]              ruse_d,
    input  logic [NSRC-1:0][ADDR_W-1:0]  ra_e,
    input  logic [NSRC-1:0]              rcls_e,
    input  logic [NSRC-1:0]              ruse_e,
    input  logic [ADDR_W-1:0]            wa_e,
    input  logic                         wcls_e,
    input  logic                         regwrite_e,
    input  logic                         memtoreg_e,
    input  logic                         multicycle_e,
    input  logic [ADDR_W-1:0]            wa_m,
    input  logic                         wcls_m,
    input  logic                         regwrite_m,
    input  logic [ADDR_W-1:0]            wa_w,
    input  logic                         wcls_w,
    input  logic                         regwrite_w,
    input  logic                         branch_taken_e,
    output logic [NSRC-1:0][1:0]         fwd_e,
    output logic                         stall_f,
    output logic                         stall_d,
    output logic                         stall_e,
    output logic                         flush_d,
    output logic                         flush_e,
    output logic                         flush_m,
    output logic                         ex_busy,
    output logic [CNT_W-1:0]             lu_stall_cnt
);

    logic [NSRC-1:0]        hit_m, hit_w, hit_lu;
    logic [NSRC-1:0][1:0]   fwd_raw;
    logic                   lu, lu_win, hold;
    logic [CNT_W-1:0]       lu_cnt_q, lu_cnt_d;

    for (genvar s = 0; s < NSRC; s++) begin : g_src
        assign hit_m[s]  = ruse_e[s] && regwrite_m && (wcls_m == rcls_e[s]) && (wa_m == ra_e[s]);
        assign hit_w[s]  = ruse_e[s] && regwrite_w && (wcls_w == rcls_e[s]) && (wa_w == ra_e[s]);
        assign hit_lu[s] = ruse_d[s] && regwrite_e && (wcls_e == rcls_d[s]) && (wa_e == ra_d[s]);
        assign fwd_raw[s] = pick_fwd(hit_m[s], hit_w[s]);
    end

    assign lu = memtoreg_e && regwrite_e && (|hit_lu);

    vec_mc_sequencer #(
        .MC_LAT (MC_LAT)
    ) u_mc_seq (
        .clk          (clk),
        .rst          (rst),
        .multicycle_e (multicycle_e),
        .hold         (hold),
        .ex_busy      (ex_busy)
    );

    // Priority: hold > branch > load-use. Everything is forced quiet in reset,
    // since hold is combinational from multicycle_e even in IDLE.
    always_comb begin
        fwd_e   = '0;
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_m = 1'b0;
        lu_win  = 1'b0;
        if (!rst) begin
            fwd_e = fwd_raw;
            if (hold) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                flush_m = 1'b1;
            end else if (branch_taken_e) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else if (lu) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
                lu_win  = 1'b1;
            end
        end
    end

    always_comb begin
        lu_cnt_d = lu_cnt_q;
        if (lu_win && (lu_cnt_q != '1)) begin
            lu_cnt_d = lu_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lu_cnt_q <= '0;
        end else begin
            lu_cnt_q <= lu_cnt_d;
        end
    end

    assign lu_stall_cnt = lu_cnt_q;

endmodule

// File: tb/tb_vec_hazard_unit.sv
module tb_vec_hazard_unit;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned NSRC   = 3;
    localparam int unsigned MC_LAT = 4;
    localparam int unsigned CNT_W  = 4;

    logic                        clk, rst;
    logic [NSRC-1:0][ADDR_W-1:0] ra_d, ra_e;
    logic [NSRC-1:0]             rcls_d, ruse_d, rcls_e, ruse_e;
    logic [ADDR_W-1:0]           wa_e, wa_m, wa_w;
    logic                        wcls_e, regwrite_e, memtoreg_e, multicycle_e;
    logic                        wcls_m, regwrite_m, wcls_w, regwrite_w, branch_taken_e;
    logic [NSRC-1:0][1:0]        fwd_e;
    logic                        stall_f, stall_d, stall_e, flush_d, flush_e, flush_m;
    logic                        ex_busy;
    logic [CNT_W-1:0]            lu_stall_cnt;
    logic [5:0]                  ctl;

    assign ctl = {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m};

    vec_hazard_unit #(
        .ADDR_W (ADDR_W),
        .NSRC   (NSRC),
        .MC_LAT (MC_LAT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ra_d           (ra_d),
        .rcls_d         (rcls_d),
        .ruse_d         (ruse_d),
        .ra_e           (ra_e),
        .rcls_e         (rcls_e),
        .ruse_e         (ruse_e),
        .wa_e           (wa_e),
        .wcls_e         (wcls_e),
        .regwrite_e     (regwrite_e),
        .memtoreg_e     (memtoreg_e),
        .multicycle_e   (multicycle_e),
        .wa_m           (wa_m),
        .wcls_m         (wcls_m),
        .regwrite_m     (regwrite_m),
        .wa_w           (wa_w),
        .wcls_w         (wcls_w),
        .regwrite_w     (regwrite_w),
        .branch_taken_e (branch_taken_e),
        .fwd_e          (fwd_e),
        .stall_f        (stall_f),
        .stall_d        (stall_d),
        .stall_e        (stall_e),
        .flush_d        (flush_d),
        .flush_e        (flush_e),
        .flush_m        (flush_m),
        .ex_busy        (ex_busy),
        .lu_stall_cnt   (lu_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctl bit order: {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m}
    typedef struct {
        logic [11:0] ra_e;  logic [2:0] rcls_e; logic [2:0] ruse_e;
        logic [3:0]  wa_m;  logic wcls_m; logic rw_m;
        logic [3:0]  wa_w;  logic wcls_w; logic rw_w;
        logic [3:0]  wa_e;  logic wcls_e; logic rw_e; logic mtr_e;
        logic [11:0] ra_d;  logic [2:0] rcls_d; logic [2:0] ruse_d;
        logic        br;
        logic [5:0]  exp_fwd; logic [5:0] exp_ctl; logic exp_inc;
    } vec_t;

    typedef struct {
        logic [5:0] fwd;
        logic [5:0] ctl;
        logic       busy;
    } exp_t;

    localparam logic [5:0] CtlHold = 6'b111001;
    localparam logic [5:0] CtlLu   = 6'b110010;
    localparam logic [5:0] CtlBr   = 6'b000110;

    vec_t  vecs[16];
    vec_t  lu_vec, fwd_vec, idle_vec;
    exp_t  exp_q[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    exp_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        ra_e = v.ra_e;  rcls_e = v.rcls_e; ruse_e = v.ruse_e;
        wa_m = v.wa_m;  wcls_m = v.wcls_m; regwrite_m = v.rw_m;
        wa_w = v.wa_w;  wcls_w = v.wcls_w; regwrite_w = v.rw_w;
        wa_e = v.wa_e;  wcls_e = v.wcls_e; regwrite_e = v.rw_e; memtoreg_e = v.mtr_e;
        ra_d = v.ra_d;  rcls_d = v.rcls_d; ruse_d = v.ruse_d;
        branch_taken_e = v.br;
    endtask

    task automatic push_exp(input logic [5:0] f, input logic [5:0] c, input logic b);
        exp_t e;
        e.fwd = f; e.ctl = c; e.busy = b;
        exp_q.push_back(e);
    endtask

    task automatic check_out(input string name);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk({name, " scoreboard empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk({name, " fwd_e"}, 32'(fwd_e), 32'(e.fwd));
            chk({name, " ctl"}, 32'(ctl), 32'(e.ctl));
            chk({name, " ex_busy"}, 32'(ex_busy), 32'(e.busy));
        end
    endtask

    // Multi-cycle op held in E; optionally a branch in cycle 2 and load-use in cycle 3.
    task automatic run_mc(input string tag, input logic with_events);
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            drive((with_events && c == 3) ? lu_vec : idle_vec);
            branch_taken_e = with_events && (c == 2);
            multicycle_e   = (c <= 4);
            push_exp(6'b0, (c < 4) ? CtlHold : 6'b0, (c >= 2) && (c <= 4));
            @(negedge clk);
            check_out($sformatf("%s cyc%0d", tag, c));
        end
        @(posedge clk); #1;
        chk({tag, " lu_stall_cnt"}, 32'(lu_stall_cnt), 32'(exp_cnt));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        idle_vec = '{12'h000, 3'b000, 3'b000, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0,
                     4'h0, 1'b0, 1'b0, 1'b0, 12'h000, 3'b000, 3'b000, 1'b0, 6'b0, 6'b0, 1'b0};
        fwd_vec  = '{12'h050, 3'b010, 3'b010, 4'h5, 1'b1, 1'b1, 4'h5, 1'b1, 1'b1,
                     4'h0, 1'b0, 1'b0, 1'b0, 12'h000, 3'b000, 3'b000, 1'b0, 6'b001000, 6'b0, 1'b0};
        lu_vec   = '{12'h000, 3'b000, 3'b000, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0,
                     4'h3, 1'b0, 1'b1, 1'b1, 12'h300, 3'b000, 3'b100, 1'b0, 6'b0, CtlLu, 1'b1};

        vecs[0]  = idle_vec;
        vecs[1]  = fwd_vec;
        vecs[2]  = fwd_vec;  vecs[2].rw_m = 1'b0;   vecs[2].exp_fwd = 6'b000100;
        vecs[3]  = fwd_vec;  vecs[3].wcls_m = 1'b0; vecs[3].exp_fwd = 6'b000100;
        vecs[4]  = fwd_vec;  vecs[4].rcls_e = 3'b000; vecs[4].exp_fwd = 6'b000000;
        vecs[5]  = '{12'h977, 3'b000, 3'b101, 4'h7, 1'b0, 1'b1, 4'h9, 1'b0, 1'b1,
                     4'h0, 1'b0, 1'b0, 1'b0, 12'h000, 3'b000, 3'b000, 1'b0, 6'b010010, 6'b0, 1'b0};
        vecs[6]  = fwd_vec;  vecs[6].rw_m = 1'b0; vecs[6].rw_w = 1'b0; vecs[6].exp_fwd = 6'b0;
        vecs[7]  = lu_vec;
        vecs[8]  = lu_vec;   vecs[8].ruse_d = 3'b000;  vecs[8].exp_ctl = 6'b0; vecs[8].exp_inc = 0;
        vecs[9]  = lu_vec;   vecs[9].rw_e = 1'b0;      vecs[9].exp_ctl = 6'b0; vecs[9].exp_inc = 0;
        vecs[10] = lu_vec;   vecs[10].rcls_d = 3'b100; vecs[10].exp_ctl = 6'b0; vecs[10].exp_inc = 0;
        vecs[11] = lu_vec;   vecs[11].mtr_e = 1'b0;    vecs[11].exp_ctl = 6'b0; vecs[11].exp_inc = 0;
        vecs[12] = lu_vec;   vecs[12].br = 1'b1;       vecs[12].exp_ctl = CtlBr; vecs[12].exp_inc = 0;
        vecs[13] = idle_vec; vecs[13].br = 1'b1;       vecs[13].exp_ctl = CtlBr;
        vecs[14] = '{12'h000, 3'b000, 3'b000, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0,
                     4'hA, 1'b1, 1'b1, 1'b1, 12'h00A, 3'b001, 3'b001, 1'b0, 6'b0, CtlLu, 1'b1};
        vecs[15] = vecs[14];

        // Reset with hazards present on the inputs: everything must stay quiet.
        rst = 1'b1;
        multicycle_e = 1'b1;
        drive(fwd_vec);
        memtoreg_e = 1'b1; regwrite_e = 1'b1; wa_e = 4'h3;
        ra_d = 12'h300; ruse_d = 3'b100; rcls_d = 3'b000;
        #2;
        push_exp(6'b0, 6'b0, 1'b0);
        check_out("in reset");
        chk("in reset lu_stall_cnt", 32'(lu_stall_cnt), 32'd0);
        @(negedge clk);
        @(negedge clk);
        multicycle_e = 1'b0;
        drive(idle_vec);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            chk($sformatf("vec%0d lu_stall_cnt", i), 32'(lu_stall_cnt), 32'(exp_cnt));
            drive(vecs[i]);
            push_exp(vecs[i].exp_fwd, vecs[i].exp_ctl, 1'b0);
            @(negedge clk);
            check_out($sformatf("vec%0d", i));
            exp_cnt += int'(vecs[i].exp_inc);
        end

        run_mc("mc_plain", 1'b0);
        run_mc("mc_events", 1'b1);

        // Asynchronous reset in the second cycle of a hold.
        @(posedge clk); #1;
        drive(fwd_vec);
        multicycle_e = 1'b1;
        push_exp(6'b001000, CtlHold, 1'b0);
        @(negedge clk);
        check_out("mcrst cyc1");
        @(posedge clk); #1;
        push_exp(6'b001000, CtlHold, 1'b1);
        check_out("mcrst cyc2");
        #1;
        rst = 1'b1;
        #1;
        push_exp(6'b0, 6'b0, 1'b0);
        check_out("mcrst in reset");
        chk("mcrst lu_stall_cnt", 32'(lu_stall_cnt), 32'd0);
        exp_cnt = 0;
        @(negedge clk);
        @(negedge clk);
        multicycle_e = 1'b0;
        drive(idle_vec);
        rst = 1'b0;
        run_mc("mc_after_rst", 1'b0);

        // Saturation of the 4-bit load-use counter.
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (i == 14 || i == 15) begin
                chk($sformatf("sat after %0d", i), 32'(lu_stall_cnt), 32'(i));
            end
            drive(lu_vec);
        end
        @(posedge clk); #1;
        chk("sat final", 32'(lu_stall_cnt), 32'd15);
        drive(idle_vec);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
